// File: rtl/corevx_lsu_ctrl_if.sv
// Execute-side request/response and data-cache command bundle for the LSU controller.
// The slave modport is the controller's view; the master modport is the execute/cache side.
interface corevx_lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [31:0] req_address;
  logic [2:0]  req_funct3;
  logic [31:0] req_store_data;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_load_data;
  logic        resp_exc;
  logic [3:0]  resp_exc_cause;
  logic        c_reset_done;
  logic [3:0]  c_cmd;
  logic [31:0] c_address;
  logic [2:0]  c_load_type;
  logic [1:0]  c_store_type;
  logic [31:0] c_store_data;
  logic [3:0]  c_response;
  logic [31:0] c_load_data;

  modport slave (
    input  req_valid, req_store, req_address, req_funct3, req_store_data,
    input  c_reset_done, c_response, c_load_data,
    output req_ready, busy, resp_valid, resp_load_data, resp_exc, resp_exc_cause,
    output c_cmd, c_address, c_load_type, c_store_type, c_store_data
  );

  modport master (
    output req_valid, req_store, req_address, req_funct3, req_store_data,
    output c_reset_done, c_response, c_load_data,
    input  req_ready, busy, resp_valid, resp_load_data, resp_exc, resp_exc_cause,
    input  c_cmd, c_address, c_load_type, c_store_type, c_store_data
  );
endinterface

// File: rtl/corevx_lsu_ctrl.sv
// Load/store sequencer: validates one execute request at a time, drives the data-cache
// port until a terminal response, then returns load data or an exception cause.
module corevx_lsu_ctrl #(
  parameter int TIMEOUT     = 1024,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  corevx_lsu_ctrl_if.slave bus
);

  localparam logic [3:0] CACHE_CMD_NONE              = 4'd0;
  localparam logic [3:0] CACHE_CMD_LOAD              = 4'd1;
  localparam logic [3:0] CACHE_CMD_STORE             = 4'd2;
  localparam logic [3:0] CACHE_RESPONSE_IDLE         = 4'd0;
  localparam logic [3:0] CACHE_RESPONSE_WAIT         = 4'd1;
  localparam logic [3:0] CACHE_RESPONSE_DONE         = 4'd2;
  localparam logic [3:0] CACHE_RESPONSE_MISSALIGNED  = 4'd3;
  localparam logic [3:0] CACHE_RESPONSE_ACCESSFAULT  = 4'd4;
  localparam logic [3:0] CACHE_RESPONSE_PAGEFAULT    = 4'd5;

  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_ACCESS   = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_ACCESS   = 4'd7;
  localparam logic [3:0] CAUSE_LD_PAGE     = 4'd13;
  localparam logic [3:0] CAUSE_ST_PAGE     = 4'd15;

  localparam int            CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {RESETWAIT, IDLE, ACTIVE, RESP} state_t;

  state_t      state, next_state;
  logic        lat_store;
  logic [31:0] lat_address;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_data;
  logic [CW-1:0] cnt;
  logic        exc_q;
  logic [3:0]  cause_q;
  logic [31:0] load_data_q;

  logic        req_illegal;
  logic        req_misaligned;
  logic        enter_resp;
  logic        next_exc;
  logic [3:0]  next_cause;
  logic        capture_load;

  // Request validation is done on the live execute inputs so the error path needs no cache cycle.
  always_comb begin
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    if (bus.req_store)
      req_illegal = bus.req_funct3[2] || (bus.req_funct3 == 3'd3);
    else
      req_illegal = (bus.req_funct3 == 3'd3) || (bus.req_funct3 == 3'd6) ||
                    (bus.req_funct3 == 3'd7);
    case (bus.req_funct3[1:0])
      2'b01:   req_misaligned = bus.req_address[0];
      2'b10:   req_misaligned = (bus.req_address[1:0] != 2'b00);
      default: req_misaligned = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RESETWAIT;
    else        state <= next_state;
  end

  always_comb begin
    next_state   = state;
    enter_resp   = 1'b0;
    next_exc     = 1'b0;
    next_cause   = 4'd0;
    capture_load = 1'b0;
    case (state)
      RESETWAIT: begin
        if (bus.c_reset_done) next_state = IDLE;
      end
      IDLE: begin
        if (bus.req_valid) begin
          if (req_illegal) begin
            next_state = RESP;
            enter_resp = 1'b1;
            next_exc   = 1'b1;
            next_cause = CAUSE_ILLEGAL;
          end else if (ALIGN_CHECK && req_misaligned) begin
            next_state = RESP;
            enter_resp = 1'b1;
            next_exc   = 1'b1;
            next_cause = bus.req_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
          end else begin
            next_state = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        case (bus.c_response)
          CACHE_RESPONSE_DONE: begin
            next_state   = RESP;
            enter_resp   = 1'b1;
            capture_load = !lat_store;
          end
          CACHE_RESPONSE_MISSALIGNED: begin
            next_state = RESP;
            enter_resp = 1'b1;
            next_exc   = 1'b1;
            next_cause = lat_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
          end
          CACHE_RESPONSE_ACCESSFAULT: begin
            next_state = RESP;
            enter_resp = 1'b1;
            next_exc   = 1'b1;
            next_cause = lat_store ? CAUSE_ST_ACCESS : CAUSE_LD_ACCESS;
          end
          CACHE_RESPONSE_PAGEFAULT: begin
            next_state = RESP;
            enter_resp = 1'b1;
            next_exc   = 1'b1;
            next_cause = lat_store ? CAUSE_ST_PAGE : CAUSE_LD_PAGE;
          end
          default: begin
            // WAIT, IDLE and unknown encodings all count towards the watchdog.
            if (cnt == TMAX) begin
              next_state = RESP;
              enter_resp = 1'b1;
              next_exc   = 1'b1;
              next_cause = lat_store ? CAUSE_ST_ACCESS : CAUSE_LD_ACCESS;
            end
          end
        endcase
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = RESETWAIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_store   <= 1'b0;
      lat_address <= 32'd0;
      lat_funct3  <= 3'd0;
      lat_data    <= 32'd0;
      cnt         <= '0;
      exc_q       <= 1'b0;
      cause_q     <= 4'd0;
      load_data_q <= 32'd0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        lat_store   <= bus.req_store;
        lat_address <= bus.req_address;
        lat_funct3  <= bus.req_funct3;
        lat_data    <= bus.req_store_data;
      end
      if (state == ACTIVE) cnt <= cnt + 1'b1;
      else                 cnt <= '0;
      if (enter_resp) begin
        exc_q   <= next_exc;
        cause_q <= next_cause;
        if (capture_load) load_data_q <= bus.c_load_data;
      end
    end
  end

  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.busy       = (state != IDLE);
    bus.resp_valid = (state == RESP);
    bus.c_cmd      = CACHE_CMD_NONE;
    if (state == ACTIVE)
      bus.c_cmd = lat_store ? CACHE_CMD_STORE : CACHE_CMD_LOAD;
  end

  assign bus.c_address      = lat_address;
  assign bus.c_load_type    = lat_funct3;
  assign bus.c_store_type   = lat_funct3[1:0];
  assign bus.c_store_data   = lat_data;
  assign bus.resp_exc       = exc_q;
  assign bus.resp_exc_cause = cause_q;
  assign bus.resp_load_data = load_data_q;

endmodule

// File: tb/tb_corevx_lsu_ctrl.sv
// Directed bench for corevx_lsu_ctrl with a short watchdog (TIMEOUT=8) and local alignment checks.
module tb_corevx_lsu_ctrl;

  localparam logic [3:0] CMD_NONE  = 4'd0;
  localparam logic [3:0] CMD_LOAD  = 4'd1;
  localparam logic [3:0] CMD_STORE = 4'd2;
  localparam logic [3:0] RSP_IDLE  = 4'd0;
  localparam logic [3:0] RSP_WAIT  = 4'd1;
  localparam logic [3:0] RSP_DONE  = 4'd2;
  localparam logic [3:0] RSP_AF    = 4'd4;
  localparam logic [3:0] RSP_PF    = 4'd5;

  logic clk = 1'b0;
  logic rst_n;
  int   check_count = 0;
  int   pass_count  = 0;
  int   fail_count  = 0;

  corevx_lsu_ctrl_if bus();

  corevx_lsu_ctrl #(.TIMEOUT(8), .ALIGN_CHECK(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single edge; afterwards we sit in the cycle after the handshake.
  task automatic apply_stimulus(input logic store, input logic [31:0] addr,
                                input logic [2:0] f3, input logic [31:0] data);
    bus.req_valid      = 1'b1;
    bus.req_store      = store;
    bus.req_address    = addr;
    bus.req_funct3     = f3;
    bus.req_store_data = data;
    tick();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n              = 1'b0;
    bus.req_valid      = 1'b0;
    bus.req_store      = 1'b0;
    bus.req_address    = 32'd0;
    bus.req_funct3     = 3'd0;
    bus.req_store_data = 32'd0;
    bus.c_reset_done   = 1'b0;
    bus.c_response     = RSP_IDLE;
    bus.c_load_data    = 32'd0;

    // Reset held for three edges, cache not yet reset
    tick();
    check_output("rst_req_ready", bus.req_ready, 0);
    check_output("rst_busy", bus.busy, 1);
    check_output("rst_resp_valid", bus.resp_valid, 0);
    check_output("rst_resp_exc", bus.resp_exc, 0);
    check_output("rst_cause", bus.resp_exc_cause, 0);
    check_output("rst_load_data", bus.resp_load_data, 0);
    check_output("rst_c_cmd", bus.c_cmd, CMD_NONE);
    check_output("rst_c_address", bus.c_address, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_output("rw_req_ready", bus.req_ready, 0);
    check_output("rw_busy", bus.busy, 1);
    bus.req_valid   = 1'b1;
    bus.req_address = 32'h0000_0040;
    bus.req_funct3  = 3'd2;
    tick();
    bus.req_valid = 1'b0;
    check_output("rw_ignore_cmd", bus.c_cmd, CMD_NONE);
    check_output("rw_ignore_ready", bus.req_ready, 0);
    bus.c_reset_done = 1'b1;
    tick();
    check_output("idle_req_ready", bus.req_ready, 1);
    check_output("idle_busy", bus.busy, 0);
    check_output("idle_c_cmd", bus.c_cmd, CMD_NONE);

    // Load word, three WAITs then DONE
    bus.c_response = RSP_WAIT;
    apply_stimulus(1'b0, 32'h0000_1000, 3'd2, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check_output("lw_c_cmd", bus.c_cmd, CMD_LOAD);
      check_output("lw_c_address", bus.c_address, 32'h0000_1000);
      check_output("lw_resp_valid", bus.resp_valid, 0);
      check_output("lw_busy", bus.busy, 1);
      if (i == 3) begin
        bus.c_response  = RSP_DONE;
        bus.c_load_data = 32'hDEAD_BEEF;
      end
      tick();
    end
    check_output("lw_c_load_type", bus.c_load_type, 2);
    check_output("lw_resp_valid_pulse", bus.resp_valid, 1);
    check_output("lw_resp_exc", bus.resp_exc, 0);
    check_output("lw_load_data", bus.resp_load_data, 32'hDEAD_BEEF);
    check_output("lw_cmd_released", bus.c_cmd, CMD_NONE);
    check_output("lw_resp_busy", bus.busy, 1);
    bus.c_response  = RSP_IDLE;
    bus.c_load_data = 32'h1234_5678;
    tick();
    check_output("lw_resp_one_cycle", bus.resp_valid, 0);
    check_output("lw_back_idle", bus.req_ready, 1);
    check_output("lw_data_held", bus.resp_load_data, 32'hDEAD_BEEF);

    // Misaligned store halfword caught locally
    apply_stimulus(1'b1, 32'h0000_2001, 3'd1, 32'hCAFE_F00D);
    check_output("sh_mis_resp_valid", bus.resp_valid, 1);
    check_output("sh_mis_exc", bus.resp_exc, 1);
    check_output("sh_mis_cause", bus.resp_exc_cause, 6);
    check_output("sh_mis_c_cmd", bus.c_cmd, CMD_NONE);
    check_output("sh_mis_c_store_data", bus.c_store_data, 32'hCAFE_F00D);
    check_output("sh_mis_c_store_type", bus.c_store_type, 1);
    tick();
    check_output("sh_mis_idle", bus.req_ready, 1);

    // Misaligned load word caught locally
    apply_stimulus(1'b0, 32'h0000_1002, 3'd2, 32'h0);
    check_output("lw_mis_resp_valid", bus.resp_valid, 1);
    check_output("lw_mis_cause", bus.resp_exc_cause, 4);
    check_output("lw_mis_c_cmd", bus.c_cmd, CMD_NONE);
    tick();

    // Illegal store funct3
    apply_stimulus(1'b1, 32'h0000_3000, 3'd4, 32'h0000_0011);
    check_output("st_ill_resp_valid", bus.resp_valid, 1);
    check_output("st_ill_exc", bus.resp_exc, 1);
    check_output("st_ill_cause", bus.resp_exc_cause, 2);
    check_output("st_ill_c_cmd", bus.c_cmd, CMD_NONE);
    tick();

    // Illegal load funct3
    apply_stimulus(1'b0, 32'h0000_3000, 3'd6, 32'h0);
    check_output("ld_ill_cause", bus.resp_exc_cause, 2);
    tick();

    // Load page fault, then back-to-back store access fault
    bus.c_response = RSP_PF;
    apply_stimulus(1'b0, 32'h0000_4000, 3'd0, 32'h0);
    check_output("pf_c_cmd", bus.c_cmd, CMD_LOAD);
    tick();
    check_output("pf_resp_valid", bus.resp_valid, 1);
    check_output("pf_exc", bus.resp_exc, 1);
    check_output("pf_cause", bus.resp_exc_cause, 13);
    bus.c_response     = RSP_AF;
    bus.req_valid      = 1'b1;
    bus.req_store      = 1'b1;
    bus.req_address    = 32'h0000_5004;
    bus.req_funct3     = 3'd2;
    bus.req_store_data = 32'hA5A5_A5A5;
    tick();
    check_output("b2b_idle_ready", bus.req_ready, 1);
    check_output("b2b_idle_resp_valid", bus.resp_valid, 0);
    tick();
    bus.req_valid = 1'b0;
    check_output("af_c_cmd", bus.c_cmd, CMD_STORE);
    check_output("af_c_address", bus.c_address, 32'h0000_5004);
    check_output("af_c_store_data", bus.c_store_data, 32'hA5A5_A5A5);
    check_output("af_c_store_type", bus.c_store_type, 2);
    tick();
    check_output("af_resp_valid", bus.resp_valid, 1);
    check_output("af_cause", bus.resp_exc_cause, 7);
    bus.c_response = RSP_IDLE;
    tick();
    check_output("af_back_idle", bus.req_ready, 1);

    // Successful store clears the exception flag
    bus.c_response = RSP_DONE;
    apply_stimulus(1'b1, 32'h0000_5008, 3'd0, 32'h0000_00FF);
    check_output("sb_c_cmd", bus.c_cmd, CMD_STORE);
    tick();
    check_output("sb_resp_valid", bus.resp_valid, 1);
    check_output("sb_resp_exc", bus.resp_exc, 0);
    bus.c_response = RSP_IDLE;
    tick();

    // Cache stuck in WAIT: watchdog forces a load access fault after 8 ACTIVE cycles
    bus.c_response = RSP_WAIT;
    apply_stimulus(1'b0, 32'h0000_6000, 3'd2, 32'h0);
    for (int i = 0; i < 8; i++) begin
      check_output("to_c_cmd", bus.c_cmd, CMD_LOAD);
      check_output("to_resp_valid", bus.resp_valid, 0);
      tick();
    end
    check_output("to_resp_valid_pulse", bus.resp_valid, 1);
    check_output("to_exc", bus.resp_exc, 1);
    check_output("to_cause", bus.resp_exc_cause, 5);
    check_output("to_c_cmd_none", bus.c_cmd, CMD_NONE);
    tick();

    // Reset in the middle of an access
    apply_stimulus(1'b0, 32'h0000_7000, 3'd2, 32'h0);
    check_output("mr_c_cmd_active", bus.c_cmd, CMD_LOAD);
    rst_n = 1'b0;
    tick();
    check_output("mr_c_cmd", bus.c_cmd, CMD_NONE);
    check_output("mr_resp_valid", bus.resp_valid, 0);
    check_output("mr_req_ready", bus.req_ready, 0);
    check_output("mr_busy", bus.busy, 1);
    check_output("mr_c_address", bus.c_address, 0);
    rst_n            = 1'b1;
    bus.c_reset_done = 1'b0;
    tick();
    check_output("mr_wait_resp_valid", bus.resp_valid, 0);
    check_output("mr_wait_ready", bus.req_ready, 0);
    bus.c_reset_done = 1'b1;
    tick();
    check_output("mr_idle_ready", bus.req_ready, 1);
    check_output("mr_idle_busy", bus.busy, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
